// File: rtl/sha3_state_gather_if.sv
// Beat-stream in / full-state strobe out bundle for
// the Keccak state gather stage.
interface sha3_state_gather_if #(
  parameter int LANE_W         = 64,
  parameter int LANES_PER_BEAT = 5
);
  logic                             in_valid;
  logic                             in_ready;
  logic [LANES_PER_BEAT*LANE_W-1:0] in_data;
  logic                             flush;
  logic                             out_ready;
  logic                             out_sample;
  logic [25*LANE_W-1:0]             out_lanes;
  logic [1:0]                       pending;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_sample, out_lanes, pending
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_sample, out_lanes, pending
  );
endinterface

// File: rtl/sha3_state_gather.sv
// Gathers 25 lanes from a narrow beat stream into two
// ping-pong slots and strobes each full state out.
module sha3_state_gather #(
  parameter int LANE_W         = 64,
  parameter int LANES_PER_BEAT = 5
) (
  input logic                clk,
  input logic                rstn,
  sha3_state_gather_if.slave bus
);

  localparam int B      = 25 / LANES_PER_BEAT;
  localparam int BEAT_W = LANES_PER_BEAT * LANE_W;
  localparam int ST_W   = 25 * LANE_W;
  localparam int CW     = (B > 1) ? $clog2(B) : 1;
  localparam int OW     = $clog2(ST_W);

  if (!(LANE_W == 8 || LANE_W == 16 ||
        LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
    $error("sha3_state_gather: illegal LANE_W");
  end

  if (!(LANES_PER_BEAT == 1 || LANES_PER_BEAT == 5 ||
        LANES_PER_BEAT == 25)) begin : g_bad_lpb
    $error("sha3_state_gather: illegal LANES_PER_BEAT");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } slot_e;

  slot_e            r_st [2];
  logic [ST_W-1:0]  r_slot [2];
  logic             r_wr;
  logic             r_rd;
  logic [CW-1:0]    r_cnt;
  logic             r_sample;
  logic [ST_W-1:0]  r_lanes;

  logic             w_ready;
  logic             w_acc;
  logic             w_last;
  logic             w_rel;
  logic [OW-1:0]    w_off;

  // The write slot refuses beats once it holds a
  // complete state; flush also blocks the beat.
  assign w_ready = rstn & (r_st[r_wr] != S_FULL) &
                   ~bus.flush;
  assign w_acc   = bus.in_valid & w_ready;
  assign w_last  = (r_cnt == CW'(B - 1));
  assign w_rel   = (r_st[r_rd] == S_FULL) &
                   bus.out_ready;
  assign w_off   = OW'(r_cnt) * OW'(BEAT_W);

  // Slot state machine, pointers, beat counter
  // and the registered output strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st[0]  <= S_EMPTY;
      r_st[1]  <= S_EMPTY;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= '0;
      r_sample <= 1'b0;
      r_lanes  <= '0;
    end else begin
      r_sample <= w_rel;
      if (w_rel) begin
        r_lanes    <= r_slot[r_rd];
        r_st[r_rd] <= S_EMPTY;
        r_rd       <= ~r_rd;
      end
      if (bus.flush) begin
        if (r_st[r_wr] == S_FILL)
          r_st[r_wr] <= S_EMPTY;
        r_cnt <= '0;
      end else if (w_acc) begin
        if (w_last) begin
          r_st[r_wr] <= S_FULL;
          r_cnt      <= '0;
          r_wr       <= ~r_wr;
        end else begin
          r_st[r_wr] <= S_FILL;
          r_cnt      <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Lane storage: each accepted beat lands at its
  // lane offset inside the current write slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
    end else if (w_acc) begin
      r_slot[r_wr][w_off +: BEAT_W] <= bus.in_data;
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_sample = r_sample;
  assign bus.out_lanes  = r_lanes;
  assign bus.pending    =
    {1'b0, (r_st[0] == S_FULL)} +
    {1'b0, (r_st[1] == S_FULL)};

endmodule

// File: tb/tb_sha3_state_gather.sv
// Bench for sha3_state_gather: queue-based reference
// model plus directed and random beat streams.
module tb_sha3_state_gather;

  localparam int LW  = 64;
  localparam int LPB = 5;
  localparam int NB  = 25 / LPB;
  localparam int BW  = LW * LPB;
  localparam int SW  = 25 * LW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha3_state_gather_if #(.LANE_W(64), .LANES_PER_BEAT(5)) a ();
  sha3_state_gather_if #(.LANE_W(8), .LANES_PER_BEAT(25)) b ();

  sha3_state_gather #(.LANE_W(64), .LANES_PER_BEAT(5))
    u_dut1 (.clk(clk), .rstn(rstn), .bus(a));
  sha3_state_gather #(.LANE_W(8), .LANES_PER_BEAT(25))
    u_dut2 (.clk(clk), .rstn(rstn), .bus(b));

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_st1(input string nm,
                         input logic [SW-1:0] st,
                         input logic [63:0] base);
    int bad;
    bad = -1;
    tests++;
    for (int i = 0; i < 25; i++)
      if (bad < 0 && st[i*64 +: 64] !== base + 64'(i))
        bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s lane%0d act=%0h exp=%0h",
               nm, bad, st[bad*64 +: 64],
               base + 64'(bad));
    end
  endtask

  task automatic chk_st2(input string nm,
                         input logic [199:0] st,
                         input int n);
    int bad;
    logic [7:0] e;
    bad = -1;
    tests++;
    for (int i = 0; i < 25; i++) begin
      e = 8'(n * 25 + i);
      if (bad < 0 && st[i*8 +: 8] !== e) bad = i;
    end
    if (bad >= 0) begin
      fails++;
      e = 8'(n * 25 + bad);
      $display("FAIL %s lane%0d act=%0h exp=%0h",
               nm, bad, st[bad*8 +: 8], e);
    end
  endtask

  function automatic logic [BW-1:0] mkb(
    input logic [63:0] base, input int k);
    logic [BW-1:0] d;
    for (int j = 0; j < LPB; j++)
      d[j*64 +: 64] = base + 64'(k * LPB + j);
    return d;
  endfunction

  function automatic logic [BW-1:0] rndb();
    logic [BW-1:0] d;
    for (int w = 0; w < BW / 32; w++)
      d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: a FIFO of at most two complete
  // states plus a partial lane buffer.
  logic [SW-1:0] mq[$];
  logic [LW-1:0] mpart[25];
  int            mbeats;
  logic          m_sample;
  logic [SW-1:0] m_lanes;

  always @(posedge clk or negedge rstn) begin
    bit rel;
    bit acc;
    logic [SW-1:0] st;
    if (!rstn) begin
      mq.delete();
      mbeats   = 0;
      m_sample = 1'b0;
      m_lanes  = '0;
    end else begin
      rel = (mq.size() > 0) && a.out_ready;
      acc = a.in_valid && !a.flush && (mq.size() < 2);
      m_sample = rel;
      if (rel) m_lanes = mq.pop_front();
      if (a.flush) begin
        mbeats = 0;
      end else if (acc) begin
        for (int j = 0; j < LPB; j++)
          mpart[mbeats*LPB + j] = a.in_data[j*64 +: 64];
        mbeats++;
        if (mbeats == NB) begin
          for (int i = 0; i < 25; i++)
            st[i*64 +: 64] = mpart[i];
          mq.push_back(st);
          mbeats = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int bad;
    chk("in_ready", a.in_ready,
        rstn && !a.flush && (mq.size() < 2));
    chk("out_sample", a.out_sample, m_sample);
    chk("pending", a.pending, mq.size());
    bad = -1;
    tests++;
    for (int i = 0; i < 25; i++)
      if (bad < 0 &&
          a.out_lanes[i*64 +: 64] !== m_lanes[i*64 +: 64])
        bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL out_lanes lane%0d act=%0h exp=%0h",
               bad, a.out_lanes[bad*64 +: 64],
               m_lanes[bad*64 +: 64]);
    end
  end

  int            s1_cyc[$];
  logic [SW-1:0] s1_st[$];
  int            s2_cyc[$];
  logic [199:0]  s2_st[$];

  always @(negedge clk) begin
    if (a.out_sample === 1'b1) begin
      s1_cyc.push_back(cyc);
      s1_st.push_back(a.out_lanes);
    end
    if (b.out_sample === 1'b1) begin
      s2_cyc.push_back(cyc);
      s2_st.push_back(b.out_lanes);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [BW-1:0] d);
    bit acc;
    acc = 1'b0;
    a.in_valid = 1'b1;
    a.in_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = a.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("beat_accept", acc, 1);
    a.in_valid = 1'b0;
  endtask

  task automatic state(input logic [63:0] base,
                       input int nbeats);
    for (int k = 0; k < nbeats; k++) beat(mkb(base, k));
  endtask

  task automatic clr();
    s1_cyc.delete();
    s1_st.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    a.in_valid  = 1'b0;
    a.in_data   = '0;
    a.flush     = 1'b0;
    a.out_ready = 1'b0;
    b.in_valid  = 1'b0;
    b.in_data   = '0;
    b.flush     = 1'b0;
    b.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready1", a.in_ready, 0);
    chk("rst_ready2", b.in_ready, 0);
    chk("rst_pending", a.pending, 0);
    tick(2);
    #2 rstn = 1'b1;
    tick(1);

    // basic fill
    a.out_ready = 1'b1;
    clr();
    state(64'h1000, 5);
    e = cyc;
    tick(4);
    chk("basic_count", s1_cyc.size(), 1);
    chk("basic_latency", s1_cyc[0], e + 1);
    chk_st1("basic_lanes", s1_st[0], 64'h1000);
    chk("basic_pending", a.pending, 0);

    // backpressure
    a.out_ready = 1'b0;
    clr();
    state(64'h2000, 5);
    state(64'h2100, 5);
    @(negedge clk);
    chk("bp_pending", a.pending, 2);
    chk("bp_ready_low", a.in_ready, 0);
    tick(1);
    a.out_ready = 1'b1;
    state(64'h2200, 5);
    tick(4);
    chk("bp_count", s1_cyc.size(), 3);
    chk("bp_consec", s1_cyc[1] - s1_cyc[0], 1);
    chk_st1("bp_st1", s1_st[0], 64'h2000);
    chk_st1("bp_st2", s1_st[1], 64'h2100);
    chk_st1("bp_st3", s1_st[2], 64'h2200);

    // flush discards partial state A
    clr();
    state(64'hA000, 3);
    a.flush = 1'b1;
    a.in_valid = 1'b1;
    a.in_data = mkb(64'hA000, 3);
    @(negedge clk);
    chk("flush_ready_low", a.in_ready, 0);
    tick(1);
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    state(64'hB000, 5);
    tick(4);
    chk("flush_count", s1_cyc.size(), 1);
    chk_st1("flush_lanes", s1_st[0], 64'hB000);

    // reset mid-operation
    a.out_ready = 1'b0;
    clr();
    state(64'hC000, 5);
    state(64'hD000, 2);
    @(posedge clk);
    #3 rstn = 1'b0;
    @(negedge clk);
    chk("mrst_pending", a.pending, 0);
    chk("mrst_sample", a.out_sample, 0);
    chk("mrst_ready", a.in_ready, 0);
    chk("mrst_lanes", a.out_lanes == '0, 1);
    @(posedge clk);
    #3 rstn = 1'b1;
    tick(1);
    a.out_ready = 1'b1;
    tick(3);
    chk("mrst_no_strobe", s1_cyc.size(), 0);
    state(64'hE000, 5);
    tick(4);
    chk("mrst_count", s1_cyc.size(), 1);
    chk_st1("mrst_lanes_after", s1_st[0], 64'hE000);

    // completion and release on the same edge
    a.out_ready = 1'b0;
    clr();
    state(64'hF000, 5);
    state(64'h5000, 4);
    a.out_ready = 1'b1;
    beat(mkb(64'h5000, 4));
    e = cyc;
    @(negedge clk);
    chk("col_pending", a.pending, 1);
    tick(4);
    chk("col_count", s1_cyc.size(), 2);
    chk("col_first", s1_cyc[0], e);
    chk_st1("col_st1", s1_st[0], 64'hF000);
    chk_st1("col_st2", s1_st[1], 64'h5000);

    // random traffic, backpressure and flushes
    for (int n = 0; n < 1500; n++) begin
      a.out_ready = ($urandom_range(0, 2) != 0);
      a.in_valid  = ($urandom_range(0, 9) < 7);
      a.in_data   = rndb();
      a.flush     = ($urandom_range(0, 39) == 0);
      tick(1);
    end
    a.in_valid  = 1'b0;
    a.flush     = 1'b0;
    a.out_ready = 1'b1;
    tick(5);
    chk("rnd_drained", a.pending, 0);

    // full rate on the 25-lane-beat instance
    s2_cyc.delete();
    s2_st.delete();
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 25; i++)
        b.in_data[i*8 +: 8] = 8'(n * 25 + i);
      b.in_valid = 1'b1;
      @(negedge clk);
      chk("fr_in_ready", b.in_ready, 1);
      tick(1);
    end
    b.in_valid = 1'b0;
    tick(4);
    chk("fr_count", s2_cyc.size(), 10);
    for (int n = 0; n < 10; n++) begin
      chk("fr_consec", s2_cyc[n] - s2_cyc[0], n);
      chk_st2("fr_lanes", s2_st[n], n);
    end
    chk("fr_pending", b.pending, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
